// File: rtl/iob_regfile_sp_ctrl_pkg.sv
// Shared definitions for the single-port regfile controller: command op codes,
// FSM state encoding and the op-to-first-state decode.
package iob_regfile_sp_ctrl_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_WRITE = 2'd0;
    localparam op_t OP_READ  = 2'd1;
    localparam op_t OP_FILL  = 2'd2;
    localparam op_t OP_DUMP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD      = 3'd2,
        ST_FILL    = 3'd3,
        ST_DUMP_RD = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    // First state entered after a command with the given op is accepted.
    function automatic state_t op_to_state(input op_t op);
        case (op)
            OP_WRITE: return ST_WR;
            OP_READ:  return ST_RD;
            OP_FILL:  return ST_FILL;
            default:  return ST_DUMP_RD;
        endcase
    endfunction

endpackage

// File: rtl/iob_regfile_sp_ctrl_if.sv
// Command and response streams of the regfile controller. The master side is
// the command issuer (CPU/CSR block or test sequencer), the slave side is the
// controller itself. Signal names keep the controller's point of view.
interface iob_regfile_sp_ctrl_if
    import iob_regfile_sp_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    op_t               cmd_op_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic [ADDR_W-1:0] rsp_addr_o;
    logic              rsp_last_o;

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rsp_last_o
    );

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_addr_o, rsp_last_o
    );

endinterface

// File: rtl/iob_regfile_sp_ctrl_seq.sv
// Address/pattern sequencer shared by every op. It is loaded with the command
// address and data on acceptance, and FILL/DUMP advance it one word per step.
// The pattern advances in lockstep with the address, so during a FILL it
// always equals seed + (addr - start) modulo 2**DATA_W.
module iob_regfile_sp_ctrl_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] pattern_q;

    // Load on command acceptance, otherwise advance address and pattern together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            pattern_q <= '0;
        end else if (cke_i) begin
            if (load) begin
                addr_q    <= start_addr;
                pattern_q <= seed;
            end else if (step) begin
                addr_q    <= addr_q + 1'b1;
                pattern_q <= pattern_q + 1'b1;
            end
        end
    end

    assign addr    = addr_q;
    assign pattern = pattern_q;
    // Sweeps never wrap, so the all-ones address is always the final word.
    assign last    = &addr_q;

endmodule

// File: rtl/iob_regfile_sp_ctrl.sv
// Initiator-side controller for a single-port register file. Accepts WRITE,
// READ, FILL and DUMP commands, drives the regfile we/addr/d port and streams
// read data back on a valid/ready response channel. The regfile read port is
// combinational, so read data is captured in the same cycle the address is
// driven.
module iob_regfile_sp_ctrl
    import iob_regfile_sp_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    iob_regfile_sp_ctrl_if.slave bus,
    output logic                busy_o,
    output logic                rf_we_o,
    output logic [ADDR_W-1:0]   rf_addr_o,
    output logic [DATA_W-1:0]   rf_d_o,
    input  logic [DATA_W-1:0]   rf_d_i
);

    state_t state_q;
    state_t state_d;

    logic              we_q;
    logic              we_d;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic              rsp_last_q;

    logic              cmd_fire;
    logic              rsp_fire;
    logic              seq_load;
    logic              seq_step;
    logic              capture;
    logic              capture_last;

    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_pattern;
    logic              seq_last;

    // Handshakes only count on enabled cycles; with cke_i low nothing moves.
    assign cmd_fire = bus.cmd_valid_i & (state_q == ST_IDLE) & cke_i;
    assign rsp_fire = bus.rsp_ready_i & (state_q == ST_RSP) & cke_i;

    iob_regfile_sp_ctrl_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_seq (
        .clk_i      (clk_i),
        .cke_i      (cke_i),
        .rst_i      (rst_i),
        .load       (seq_load),
        .step       (seq_step),
        .start_addr (bus.cmd_addr_i),
        .seed       (bus.cmd_data_i),
        .addr       (seq_addr),
        .pattern    (seq_pattern),
        .last       (seq_last)
    );

    // Next-state logic plus the sequencer and capture strobes for this cycle.
    always_comb begin
        state_d      = state_q;
        seq_load     = 1'b0;
        seq_step     = 1'b0;
        capture      = 1'b0;
        capture_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    seq_load = 1'b1;
                    state_d  = op_to_state(bus.cmd_op_i);
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD: begin
                capture      = 1'b1;
                capture_last = 1'b1;
                state_d      = ST_RSP;
            end
            ST_FILL: begin
                if (seq_last) begin
                    state_d = ST_IDLE;
                end else begin
                    seq_step = 1'b1;
                end
            end
            ST_DUMP_RD: begin
                capture      = 1'b1;
                capture_last = seq_last;
                state_d      = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_fire) begin
                    if (rsp_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        seq_step = 1'b1;
                        state_d  = ST_DUMP_RD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write enable is registered so it lines up with the sequencer address/data.
    assign we_d = (state_d == ST_WR) || (state_d == ST_FILL);

    // State, write-enable and response registers; reset wins over cke_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_last_q <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            we_q    <= we_d;
            if (capture) begin
                rsp_data_q <= rf_d_i;
                rsp_addr_q <= seq_addr;
                rsp_last_q <= capture_last;
            end
        end
    end

    assign bus.cmd_ready_o = (state_q == ST_IDLE);
    assign bus.rsp_valid_o = (state_q == ST_RSP);
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_addr_o  = rsp_addr_q;
    assign bus.rsp_last_o  = rsp_last_q;

    assign busy_o    = (state_q != ST_IDLE);
    assign rf_we_o   = we_q & cke_i;
    assign rf_addr_o = seq_addr;
    assign rf_d_o    = seq_pattern;

endmodule

// File: tb/tb_iob_regfile_sp_ctrl.sv
// Self-checking bench for iob_regfile_sp_ctrl driving a behavioural regfile.
// The reference model turns each accepted command into the list of regfile
// writes and response words it must produce, and a compare process matches
// the DUT against those lists on every enabled cycle.
module tb_iob_regfile_sp_ctrl;
    import iob_regfile_sp_ctrl_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } item_t;

    logic              clk = 1'b0;
    logic              cke;
    logic              rst;
    logic              busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_d;
    logic [DATA_W-1:0] rf_q;
    logic              mem_clear;

    logic [DATA_W-1:0] rf_mem    [DEPTH];
    logic [DATA_W-1:0] model_mem [DEPTH];
    item_t             wq[$];
    item_t             rq[$];

    int checks      = 0;
    int errors      = 0;
    int write_count = 0;
    int rsp_count   = 0;
    int ready_mode  = 0;

    iob_regfile_sp_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_regfile_sp_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i     (clk),
        .cke_i     (cke),
        .rst_i     (rst),
        .bus       (bus),
        .busy_o    (busy),
        .rf_we_o   (rf_we),
        .rf_addr_o (rf_addr),
        .rf_d_o    (rf_d),
        .rf_d_i    (rf_q)
    );

    always #5 clk = ~clk;

    // Behavioural single-port regfile: combinational read, clocked write.
    assign rf_q = rf_mem[rf_addr];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) rf_mem[i] <= '0;
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_d;
        end
    end

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected effects of an accepted command, straight from the op rules.
    task automatic modelAccept(input op_t op, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
        case (op)
            OP_WRITE: wq.push_back('{addr: addr, data: data, last: 1'b0});
            OP_READ:  rq.push_back('{addr: addr, data: model_mem[addr], last: 1'b1});
            OP_FILL:
                for (int i = int'(addr); i < DEPTH; i++)
                    wq.push_back('{addr: ADDR_W'(i), data: data + DATA_W'(i - int'(addr)),
                                   last: 1'b0});
            default:
                for (int i = int'(addr); i < DEPTH; i++)
                    rq.push_back('{addr: ADDR_W'(i), data: model_mem[i],
                                   last: (i == DEPTH - 1)});
        endcase
    endtask

    task automatic applyStimulus(input op_t op, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data);
        int waited = 0;
        @(negedge clk); #1;
        while (!bus.cmd_ready_o) begin
            if (waited >= 400) begin
                checkOutput("cmd_ready_timeout", 32'(bus.cmd_ready_o), 1);
                return;
            end
            waited++;
            @(negedge clk); #1;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_addr_i  = addr;
        bus.cmd_data_i  = data;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        modelAccept(op, addr, data);
    endtask

    task automatic waitIdle(input int budget, output int cycles, output int writes);
        cycles = 0;
        writes = 0;
        while (1) begin
            @(negedge clk); #1;
            if (bus.cmd_ready_o) break;
            cycles++;
            if (rf_we) writes++;
            if (cycles >= budget) begin
                checkOutput("idle_timeout", 32'(bus.cmd_ready_o), 1);
                break;
            end
        end
    endtask

    // Response ready pattern: 0 = always ready, 1 = random, 2 = never ready.
    initial begin
        bus.rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       bus.rsp_ready_i = 1'b1;
                1:       bus.rsp_ready_i = 1'($urandom_range(0, 1));
                default: bus.rsp_ready_i = 1'b0;
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the expected write/response lists.
    initial begin
        item_t exp_item;
        forever begin
            @(negedge clk);
            if (rst) begin
                // nothing is expected while reset is held
            end else if (!cke) begin
                checkOutput("we_gated", 32'(rf_we), 0);
            end else begin
                checkOutput("cmd_ready", 32'(bus.cmd_ready_o),
                            32'(wq.size() == 0 && rq.size() == 0));
                checkOutput("busy", 32'(busy), 32'(wq.size() != 0 || rq.size() != 0));
                if (rf_we) begin
                    if (wq.size() == 0) begin
                        checkOutput("unexpected_write", 32'(rf_we), 0);
                    end else begin
                        exp_item = wq.pop_front();
                        checkOutput("wr_addr", 32'(rf_addr), 32'(exp_item.addr));
                        checkOutput("wr_data", rf_d, exp_item.data);
                        model_mem[exp_item.addr] = exp_item.data;
                        write_count++;
                    end
                end
                if (bus.rsp_valid_o) begin
                    if (rq.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'(bus.rsp_valid_o), 0);
                    end else begin
                        exp_item = rq[0];
                        checkOutput("rsp_data", bus.rsp_data_o, exp_item.data);
                        checkOutput("rsp_addr", 32'(bus.rsp_addr_o), 32'(exp_item.addr));
                        checkOutput("rsp_last", 32'(bus.rsp_last_o), 32'(exp_item.last));
                        if (bus.rsp_ready_i) begin
                            void'(rq.pop_front());
                            rsp_count++;
                        end
                    end
                end
            end
        end
    end

    // Global time bound so the run always terminates.
    initial begin
        #500000;
        checkOutput("watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized command mix.
    initial begin
        int c;
        int w;
        int n0;
        int wc0;
        int guard;
        logic [DATA_W-1:0] seed;
        logic [DATA_W-1:0] snap [DEPTH];

        cke             = 1'b1;
        rst             = 1'b1;
        mem_clear       = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = OP_WRITE;
        bus.cmd_addr_i  = '0;
        bus.cmd_data_i  = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        // Reset: every output low while reset is held, then ready and not busy.
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
            checkOutput("rst_rsp_last", 32'(bus.rsp_last_o), 0);
            checkOutput("rst_busy", 32'(busy), 0);
            checkOutput("rst_rf_we", 32'(rf_we), 0);
            checkOutput("rst_rsp_data", bus.rsp_data_o, 0);
            checkOutput("rst_rsp_addr", 32'(bus.rsp_addr_o), 0);
            checkOutput("rst_rf_addr", 32'(rf_addr), 0);
            checkOutput("rst_rf_d", rf_d, 0);
        end
        #1;
        rst       = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk); #1;
        checkOutput("ready_after_reset", 32'(bus.cmd_ready_o), 1);
        checkOutput("busy_after_reset", 32'(busy), 0);

        // WRITE then READ of address 5.
        applyStimulus(OP_WRITE, 4'd5, 32'hDEADBEEF);
        @(negedge clk); #1;
        checkOutput("write_we", 32'(rf_we), 1);
        checkOutput("write_addr", 32'(rf_addr), 5);
        checkOutput("write_data", rf_d, 32'hDEADBEEF);
        @(negedge clk); #1;
        checkOutput("write_done_ready", 32'(bus.cmd_ready_o), 1);
        ready_mode = 2;
        applyStimulus(OP_READ, 4'd5, 32'h0);
        @(negedge clk); #1;
        checkOutput("read_lat_cycle1", 32'(bus.rsp_valid_o), 0);
        @(negedge clk); #1;
        checkOutput("read_lat_cycle2", 32'(bus.rsp_valid_o), 1);
        checkOutput("read_data", bus.rsp_data_o, 32'hDEADBEEF);
        checkOutput("read_addr", 32'(bus.rsp_addr_o), 5);
        checkOutput("read_last", 32'(bus.rsp_last_o), 1);
        ready_mode = 0;
        waitIdle(50, c, w);

        // FILL 0 seed 32, then full DUMP at full throughput.
        applyStimulus(OP_FILL, 4'd0, 32'd32);
        waitIdle(100, c, w);
        checkOutput("fill_cycles", c, 16);
        checkOutput("fill_writes", w, 16);
        checkOutput("fill_mem0", rf_mem[0], 32'd32);
        checkOutput("fill_mem15", rf_mem[15], 32'd47);
        n0 = rsp_count;
        applyStimulus(OP_DUMP, 4'd0, 32'h0);
        waitIdle(200, c, w);
        checkOutput("dump_cycles", c, 32);
        checkOutput("dump_words", rsp_count - n0, 16);

        // DUMP under random backpressure.
        seed = $urandom;
        applyStimulus(OP_FILL, 4'd0, seed);
        waitIdle(100, c, w);
        ready_mode = 1;
        n0 = rsp_count;
        applyStimulus(OP_DUMP, 4'd3, 32'h0);
        waitIdle(400, c, w);
        checkOutput("dump_bp_words", rsp_count - n0, 13);
        ready_mode = 0;

        // FILL boundaries: data wrap near the top address, single-word sweeps.
        for (int i = 0; i < DEPTH; i++) snap[i] = rf_mem[i];
        applyStimulus(OP_FILL, 4'd14, 32'hFFFFFFFF);
        waitIdle(50, c, w);
        checkOutput("fill14_writes", w, 2);
        checkOutput("fill14_mem14", rf_mem[14], 32'hFFFFFFFF);
        checkOutput("fill14_mem15", rf_mem[15], 32'h00000000);
        for (int i = 0; i < 14; i++) checkOutput("fill14_untouched", rf_mem[i], snap[i]);
        applyStimulus(OP_FILL, 4'd15, 32'd7);
        waitIdle(50, c, w);
        checkOutput("fill15_writes", w, 1);
        checkOutput("fill15_mem15", rf_mem[15], 32'd7);
        n0 = rsp_count;
        applyStimulus(OP_DUMP, 4'd15, 32'h0);
        waitIdle(50, c, w);
        checkOutput("dump15_cycles", c, 2);
        checkOutput("dump15_words", rsp_count - n0, 1);

        // Reset during a FILL after four writes.
        for (int i = 0; i < DEPTH; i++) snap[i] = rf_mem[i];
        wc0   = write_count;
        guard = 0;
        applyStimulus(OP_FILL, 4'd0, 32'h1000);
        while (write_count < wc0 + 4 && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        checkOutput("fill_rst_reached", 32'(write_count - wc0), 4);
        rst = 1'b1;
        wq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("rst_mid_ready", 32'(bus.cmd_ready_o), 1);
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_we", 32'(rf_we), 0);
        checkOutput("rst_mid_mem3", rf_mem[3], 32'h1003);
        checkOutput("rst_mid_mem4", rf_mem[4], snap[4]);
        for (int i = 0; i < DEPTH; i++) checkOutput("rst_mid_mem", rf_mem[i], model_mem[i]);

        // Clock-enable freeze for three cycles in the middle of a DUMP.
        n0    = rsp_count;
        guard = 0;
        applyStimulus(OP_DUMP, 4'd0, 32'h0);
        while (rsp_count < n0 + 5 && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        cke = 1'b0;
        wc0 = rsp_count;
        repeat (3) begin
            @(negedge clk); #1;
            checkOutput("freeze_we", 32'(rf_we), 0);
            checkOutput("freeze_valid", 32'(bus.rsp_valid_o), 0);
            checkOutput("freeze_rf_addr", 32'(rf_addr), 5);
            checkOutput("freeze_rsp_addr", 32'(bus.rsp_addr_o), 4);
            checkOutput("freeze_busy", 32'(busy), 1);
            @(posedge clk);
        end
        #2;
        cke = 1'b1;
        checkOutput("freeze_no_handshake", rsp_count - wc0, 0);
        waitIdle(200, c, w);
        checkOutput("freeze_dump_words", rsp_count - n0, 16);

        // Randomized command mix with random backpressure.
        repeat (25) begin
            ready_mode = $urandom_range(0, 1);
            applyStimulus(op_t'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, DEPTH - 1)),
                          $urandom);
            waitIdle(400, c, w);
        end
        ready_mode = 0;
        checkOutput("writes_drained", wq.size(), 0);
        checkOutput("rsps_drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
